// File: rtl/pc_sequencer.sv
// PC register and fetch/execute sequencer for the single-cycle core.
// Adds start/stall/halt control, a run-away watchdog and a retire counter.
module pc_sequencer #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned OFFSET_W   = 7,
  parameter logic [31:0] START_PC   = 32'd0,
  parameter logic [8:0]  HALT_INSTR = 9'b111111111,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic [8:0]      instr,
  input  logic            branch,
  input  logic            zero,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [31:0]     instr_count
);

  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cyc_q, cyc_d;

  logic [PC_W-1:0] offset;
  logic            is_busy;
  logic            wd_hit;

  assign offset = {{(PC_W-OFFSET_W){instr[OFFSET_W-1]}},
                   instr[OFFSET_W-1:0]};

  assign is_busy = (state_q == FETCH) || (state_q == EXEC);
  assign wd_hit  = is_busy && (cyc_q == CW'(MAX_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    cyc_d     = cyc_q;
    if (is_busy) cyc_d = cyc_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d      = PC_W'(START_PC);
          cnt_d     = '0;
          timeout_d = 1'b0;
          cyc_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (!stall) begin
          if (instr == HALT_INSTR) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 32'd1;
            pc_d    = (branch && zero) ? pc_q + offset
                                       : pc_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Watchdog wins over halt, stall and a normal retire.
    if (wd_hit) begin
      state_d   = DONE;
      timeout_d = 1'b1;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
    end
  end

  assign imem_en     = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign busy        = is_busy;
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Main DUT uses default watchdog; second DUT has MAX_CYCLES=16.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [8:0]  instr = '0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] instr_count;

  logic        start2 = 1'b0;
  logic        imem_en2;
  logic [31:0] imem_addr2;
  logic [31:0] pc2;
  logic        busy2;
  logic        done2;
  logic        timeout2;
  logic [31:0] instr_count2;

  logic [8:0]  mem [16];
  logic        brm [16];
  logic        zm  [16];

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [8:0] HALT = 9'b111111111;
  localparam logic [8:0] NOP  = 9'b000000001;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .instr(instr), .branch(branch), .zero(zero),
    .imem_en(imem_en), .imem_addr(imem_addr), .pc(pc),
    .busy(busy), .done(done), .timeout(timeout),
    .instr_count(instr_count)
  );

  pc_sequencer #(.MAX_CYCLES(16)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start2), .stall(1'b0),
    .instr(9'b000000000), .branch(1'b1), .zero(1'b1),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .pc(pc2),
    .busy(busy2), .done(done2), .timeout(timeout2),
    .instr_count(instr_count2)
  );

  // Synchronous instruction memory with branch/zero side tables.
  always @(posedge clk) begin
    if (imem_en) begin
      instr  <= mem[imem_addr[3:0]];
      branch <= brm[imem_addr[3:0]];
      zero   <= zm[imem_addr[3:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i] = HALT;
      brm[i] = 1'b0;
      zm[i]  = 1'b0;
    end
  endtask

  task automatic put(input int a, input logic [8:0] ins,
                     input logic b, input logic z);
    mem[a] = ins;
    brm[a] = b;
    zm[a]  = z;
  endtask

  int exp_b [10] = '{0, 1, 2, 3, 4, 14, 12, 8, 9, 10};
  int nb;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    clear_mem();
    #22 rst_n = 1'b1;
    step();
    chk("rst_pc", pc, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_count", instr_count, 32'd0);

    // Run A: three sequential instructions then HALT at 3.
    for (int i = 0; i < 3; i++) put(i, NOP, 1'b0, 1'b0);
    start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) start = 1'b0;
      chk($sformatf("a_fetch_en%0d", i), {31'd0, imem_en}, 32'd1);
      chk($sformatf("a_addr%0d", i), imem_addr, i);
      chk($sformatf("a_busy%0d", i), {31'd0, busy}, 32'd1);
      step();
      chk($sformatf("a_exec_en%0d", i), {31'd0, imem_en}, 32'd0);
      step();
    end
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_done_busy", {31'd0, busy}, 32'd0);
    chk("a_count", instr_count, 32'd3);
    chk("a_pc", pc, 32'd3);
    step();
    chk("a_done_clear", {31'd0, done}, 32'd0);
    chk("a_pc_held", pc, 32'd3);
    chk("a_count_held", instr_count, 32'd3);

    // Run B: taken, not-taken and backward branches.
    clear_mem();
    for (int i = 0; i < 4; i++) put(i, NOP, 1'b0, 1'b0);
    put(4,  9'b000001010, 1'b1, 1'b1);
    put(14, 9'b001111110, 1'b1, 1'b1);
    put(12, 9'b111111100, 1'b1, 1'b1);
    put(8,  9'b000000101, 1'b1, 1'b0);
    put(9,  9'b000000101, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b_addr%0d", i), imem_addr, exp_b[i]);
      step();
      step();
    end
    chk("b_done", {31'd0, done}, 32'd1);
    chk("b_count", instr_count, 32'd9);
    chk("b_pc", pc, 32'd10);
    step();

    // Run C: wrap below 0, wrap above max, then stall at 6.
    clear_mem();
    put(0,  9'b111111100, 1'b1, 1'b1);
    put(12, 9'b000001010, 1'b1, 1'b1);
    put(6,  NOP, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("c_addr0", imem_addr, 32'd0);
    step();
    step();
    chk("c_wrap_low", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("c_wrap_high", imem_addr, 32'd6);
    step();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("c_stall_pc%0d", k), pc, 32'd6);
      chk($sformatf("c_stall_cnt%0d", k), instr_count, 32'd2);
      chk($sformatf("c_stall_en%0d", k), {31'd0, imem_en}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("c_release_en", {31'd0, imem_en}, 32'd1);
    chk("c_release_pc", pc, 32'd7);
    chk("c_release_cnt", instr_count, 32'd3);
    step();
    step();
    chk("c_done", {31'd0, done}, 32'd1);
    chk("c_count", instr_count, 32'd3);
    step();

    // Run D: async reset mid-EXEC, then restart.
    clear_mem();
    put(0, NOP, 1'b0, 1'b0);
    put(1, NOP, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("d_pre_pc", pc, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("d_rst_pc", pc, 32'd0);
    chk("d_rst_busy", {31'd0, busy}, 32'd0);
    chk("d_rst_en", {31'd0, imem_en}, 32'd0);
    chk("d_rst_cnt", instr_count, 32'd0);
    put(0, HALT, 1'b0, 1'b0);
    step();
    chk("d_rst_nodone", {31'd0, done}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("d_idle_nodone", {31'd0, done}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("d_restart_en", {31'd0, imem_en}, 32'd1);
    chk("d_restart_addr", imem_addr, 32'd0);
    step();
    step();
    chk("d_halt_done", {31'd0, done}, 32'd1);
    chk("d_halt_cnt", instr_count, 32'd0);
    step();

    // Run E: watchdog on an infinite self-branch.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (done2) break;
      if (busy2) nb++;
      step();
    end
    chk("e_done", {31'd0, done2}, 32'd1);
    chk("e_busy_cycles", nb, 32'd16);
    chk("e_timeout", {31'd0, timeout2}, 32'd1);
    chk("e_pc", pc2, 32'd0);
    step();
    chk("e_timeout_sticky", {31'd0, timeout2}, 32'd1);
    chk("e_idle_busy", {31'd0, busy2}, 32'd0);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("e_timeout_clear", {31'd0, timeout2}, 32'd0);
    chk("e_restart_busy", {31'd0, busy2}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch/execute for the single-cycle-datapath core.
- Drives the synchronous instruction memory and samples the 9-bit instruction together with the datapath's branch/zero flags.
- Commits the next PC, which is either sequential or a branch target.
- Handles start, stall and halt, and provides a run-away watchdog plus a retired-instruction counter for the benches.

Parameters:
- PC_W, 32, width of the PC and the instruction-memory address.
- OFFSET_W, 7, number of low instruction bits forming the signed branch offset.
- START_PC, 0, PC loaded on start.
- HALT_INSTR, 9'b111111111, instruction encoding that ends the program.
- MAX_CYCLES, 4096, busy-cycle limit before the watchdog forces termination.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin program execution; honoured only in IDLE.
- stall  input  1  hold the current instruction in EXEC.
- instr  input  9  instruction-memory read data; valid in EXEC.
- branch  input  1  current instruction is a branch (from control decode).
- zero  input  1  ALU zero flag for the current instruction.
- imem_en  output  1  instruction-memory read enable.
- imem_addr  output  PC_W  instruction-memory address; always equals pc.
- pc  output  PC_W  current PC.
- busy  output  1  high in FETCH and EXEC.
- done  output  1  one-cycle pulse when the program ends.
- timeout  output  1  sticky flag set when the watchdog ended the run.
- instr_count  output  32  number of retired instructions in the current run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=0; imem_en=0; busy=0; done=0; timeout=0; instr_count=0; internal cycle counter=0.
  - Reset asserted mid-run aborts immediately; no done pulse is produced.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE:
  - start=1: pc<=START_PC; instr_count<=0; timeout<=0; cycle counter<=0; go to FETCH.
  - start=0: stay in IDLE.
- FETCH:
  - imem_en=1, imem_addr=pc. Memory read latency is 1 cycle.
  - Unconditionally go to EXEC.
- EXEC (instr valid; imem_en=0):
  - stall=1: hold state, pc and count; instr must be held stable by memory/system; branch/zero ignored.
  - stall=0 and instr==HALT_INSTR: pc unchanged; count unchanged (halt is not counted); go to DONE.
  - stall=0, otherwise:
    - instr_count+=1.
    - If branch&zero: pc<=pc+sext(instr[OFFSET_W-1:0]).
    - Else: pc<=pc+1.
    - Go to FETCH.
- DONE: done=1 for exactly this cycle; go to IDLE. pc and instr_count are held until the next start.
- Throughput: 2 cycles per non-stalled instruction; start to first imem_en is 1 cycle.
- Arithmetic:
  - PC add is modulo 2^PC_W; wrap below 0 and above max is silent.
  - Offset is sign-extended from bit OFFSET_W-1; bits above OFFSET_W-1 are ignored.
  - branch without zero, or zero without branch, means sequential.
- Watchdog:
  - Cycle counter increments every cycle busy=1.
  - When the counter reaches MAX_CYCLES-1 while busy: timeout<=1, go to DONE. This takes precedence over halt and stall in the same cycle.
- start asserted while busy or in DONE is ignored (not queued).
- busy is a decode of state: IDLE→0, FETCH→1, EXEC→1, DONE→0.

Test Plan:
- Reset with rst_n=0 mid-EXEC, async between edges → pc=0, busy=0, imem_en=0, no done pulse; then start → imem_addr=START_PC one cycle later.
- Program at 0..2 of non-branch instructions, HALT at address 3 → imem_addr sequence 0,1,2,3 in alternate cycles; done one cycle after EXEC at 3; instr_count=3; pc=3.
- At pc=4: instr=9'b000001010, branch=1, zero=1 → next pc=14. At pc=8: branch=1, zero=0 → pc=9.
- At pc=12: instr=9'b111111100, branch=1, zero=1 → pc=8. At pc=0, same instr → pc=0xFFFFFFFC (wrap).
- stall held 5 cycles in EXEC at pc=6 → pc, instr_count and imem_en=0 held; after release, advance to pc=7 with exactly one count increment.
- Infinite self-branch (offset 0, branch=zero=1) with MAX_CYCLES=16 → done pulses at busy cycle 16, timeout=1; next start clears timeout.
